// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl
// Instruction-fetch front end. Issues one fetch at a time to instruction
// memory, buffers the returned instruction for decode, and tells the external
// PC register when and where to move. Redirects from the back end may arrive
// at any point of a fetch; a fetch that is already granted when a redirect
// lands is marked killed so its response is dropped.
//
// State | Meaning
// ------+--------------------------------------------------------------
// IDLE  | one cycle after reset; PC updates inhibited, no request
// REQ   | request cur_pc_i; retractable until granted
// WAIT  | granted, waiting for the response (kill marks it stale)
// HOLD  | instruction buffered and presented to decode
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   cur_pc_i           current value of the PC register
//   pc_inst_valid_o    PC register update strobe (combinational)
//   pc_dont_fetch_o    PC register update inhibit (IDLE only)
//   pc_nxt_addr_o      PC register next value (combinational)
//   redirect_valid_i   branch/jump/trap redirect from the back end
//   redirect_addr_i    redirect target, low two bits ignored
//   imem_req_o         fetch request
//   imem_addr_o        fetch address
//   imem_gnt_i         request accepted this cycle
//   imem_rvalid_i      in-order response strobe
//   imem_rdata_i       response instruction
//   id_stall_i         decode cannot accept this cycle
//   inst_valid_o       instruction presented to decode
//   inst_o             presented instruction
//   inst_addr_o        address of the presented instruction
module if_fetch_ctrl #(
    parameter int unsigned          ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]    PC_START = ADDR_W'(64'h0000_0000_8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cur_pc_i,
    output logic              pc_inst_valid_o,
    output logic              pc_dont_fetch_o,
    output logic [ADDR_W-1:0] pc_nxt_addr_o,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    input  logic              id_stall_i,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state;
    logic              kill;
    logic [ADDR_W-1:0] redir_tgt;
    logic [ADDR_W-1:0] pc_plus4;

    // Masking (rather than slicing) keeps every redirect bit in use.
    assign redir_tgt   = redirect_addr_i & ~ADDR_W'(3);
    assign pc_plus4    = cur_pc_i + ADDR_W'(4);
    assign imem_addr_o = cur_pc_i;

    // PC update is decided in the same cycle as the event that causes it.
    always_comb begin
        pc_inst_valid_o = 1'b0;
        pc_nxt_addr_o   = pc_plus4;
        if (rst) begin
            pc_nxt_addr_o = PC_START;
        end else begin
            case (state)
                S_REQ, S_HOLD: begin
                    if (redirect_valid_i) begin
                        pc_inst_valid_o = 1'b1;
                        pc_nxt_addr_o   = redir_tgt;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid_i) begin
                        pc_inst_valid_o = 1'b1;
                        pc_nxt_addr_o   = redir_tgt;
                    end else if (imem_rvalid_i && !kill) begin
                        pc_inst_valid_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            kill            <= 1'b0;
            inst_valid_o    <= 1'b0;
            inst_o          <= 32'h0;
            inst_addr_o     <= '0;
            imem_req_o      <= 1'b0;
            pc_dont_fetch_o <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    state           <= S_REQ;
                    imem_req_o      <= 1'b1;
                    pc_dont_fetch_o <= 1'b0;
                end
                S_REQ: begin
                    // Without a grant the request simply follows cur_pc_i,
                    // so a redirect needs no bookkeeping here.
                    if (imem_gnt_i) begin
                        state      <= S_WAIT;
                        imem_req_o <= 1'b0;
                        kill       <= redirect_valid_i;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        kill <= 1'b0;
                        if (redirect_valid_i || kill) begin
                            state      <= S_REQ;
                            imem_req_o <= 1'b1;
                        end else begin
                            state        <= S_HOLD;
                            inst_valid_o <= 1'b1;
                            inst_o       <= imem_rdata_i;
                            inst_addr_o  <= cur_pc_i;
                        end
                    end else if (redirect_valid_i) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Redirect drops the buffer even when decode is stalled.
                    if (redirect_valid_i || !id_stall_i) begin
                        state        <= S_REQ;
                        inst_valid_o <= 1'b0;
                        imem_req_o   <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
